// File: rtl/usrt_pkg.sv
// Shared state encoding, constants and helpers for the USRT receive controller.
package usrt_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RX    = 2'd2,
        ST_FLUSH = 2'd3
    } rx_state_e;

    // A frame lasts at most this many bit periods; sets the watchdog limit.
    localparam int TIMEOUT_BITS = 11;
    // Extra idle cycles required after the line has been seen high for a full bit.
    localparam int GUARD_CYCLES = 2;

    function automatic logic [7:0] clamp_baud(input logic [7:0] baud, input logic [7:0] min_baud);
        return (baud < min_baud) ? min_baud : baud;
    endfunction

endpackage

// File: rtl/usrt_rx_fifo.sv
// Show-ahead receive FIFO; a push into a full FIFO is accepted only if a pop frees a slot that cycle.
module usrt_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       i_Pclk,
    input  logic                       i_Rst,
    input  logic                       i_Push,
    input  logic [WIDTH-1:0]           i_Wr_Data,
    input  logic                       i_Pop,
    output logic [WIDTH-1:0]           o_Rd_Data,
    output logic                       o_Full,
    output logic                       o_Empty,
    output logic [$clog2(DEPTH):0]     o_Count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_en, rd_en;

    assign o_Empty   = (count_q == '0);
    assign o_Full    = (count_q == (AW+1)'(DEPTH));
    assign o_Count   = count_q;
    assign o_Rd_Data = mem_q[rd_ptr_q];
    assign rd_en     = i_Pop && !o_Empty;
    assign wr_en     = i_Push && (!o_Full || rd_en);

    // NOTE: storage has no reset; o_Empty masks stale contents, which keeps the array a plain RAM.
    always_ff @(posedge i_Pclk) begin
        if (wr_en) mem_q[wr_ptr_q] <= i_Wr_Data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Pclk) begin
        if (i_Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/usrt_rx_ctrl.sv
// Receive controller: sequences the shifter, holds the baud divider, buffers bytes and watches each frame.
module usrt_rx_ctrl
    import usrt_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int DEFAULT_BAUD = 16,
    parameter int MIN_BAUD     = 4
) (
    input  logic                          i_Pclk,
    input  logic                          i_Rst,
    input  logic                          i_Cfg_Wr,
    input  logic [7:0]                    i_Cfg_Baud,
    input  logic                          i_Cfg_En,
    input  logic                          i_Clr_Err,
    input  logic                          i_Rx_Serial,
    input  logic [7:0]                    i_Shift_Data,
    input  logic                          i_Shift_Done,
    output logic [7:0]                    o_Baud,
    output logic                          o_Rx_Enable,
    output logic [7:0]                    o_Rd_Data,
    output logic                          o_Rd_Valid,
    input  logic                          i_Rd_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Count,
    output logic                          o_Busy,
    output logic                          o_Overrun,
    output logic                          o_Timeout
);
    rx_state_e   state_q, state_d;
    logic [7:0]  baud_q, baud_d;
    logic [7:0]  pend_baud_q, pend_baud_d;
    logic        pend_en_q, pend_en_d;
    logic        pend_vld_q, pend_vld_d;
    logic [11:0] limit_q, limit_d;
    logic [11:0] wdog_q, wdog_d;
    logic [8:0]  flush_cnt_q, flush_cnt_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;

    logic        push, timeout_set, fifo_full, fifo_empty, pop_fire;
    logic        cfg_window, apply, apply_en;
    logic [7:0]  wr_baud, apply_baud, eff_baud;
    logic [8:0]  flush_end;

    // A config takes effect only while no frame is in flight; otherwise it waits in the pending register.
    assign wr_baud    = clamp_baud(i_Cfg_Baud, 8'(MIN_BAUD));
    assign cfg_window = (state_q == ST_OFF) || (state_q == ST_IDLE);
    assign apply      = cfg_window && (i_Cfg_Wr || pend_vld_q);
    assign apply_baud = i_Cfg_Wr ? wr_baud : pend_baud_q;
    assign apply_en   = i_Cfg_Wr ? i_Cfg_En : pend_en_q;
    assign eff_baud   = apply ? apply_baud : baud_q;
    assign flush_end  = {1'b0, baud_q} + 9'(GUARD_CYCLES);
    assign pop_fire   = !fifo_empty && i_Rd_Ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        pend_baud_d = pend_baud_q;
        pend_en_d   = pend_en_q;
        pend_vld_d  = pend_vld_q;
        limit_d     = limit_q;
        wdog_d      = wdog_q;
        flush_cnt_d = flush_cnt_q;
        push        = 1'b0;
        timeout_set = 1'b0;

        if (i_Cfg_Wr && !cfg_window) begin
            pend_baud_d = wr_baud;
            pend_en_d   = i_Cfg_En;
            pend_vld_d  = 1'b1;
        end
        if (apply) begin
            baud_d     = apply_baud;
            pend_vld_d = 1'b0;
        end

        case (state_q)
            ST_OFF: begin
                if (apply && apply_en) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (apply && !apply_en) begin
                    state_d = ST_OFF;
                end else if (!i_Rx_Serial) begin
                    state_d = ST_RX;
                    wdog_d  = '0;
                    limit_d = 12'(eff_baud) * 12'(TIMEOUT_BITS);
                end
            end
            ST_RX: begin
                wdog_d = wdog_q + 12'd1;
                if (i_Shift_Done) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end else if (wdog_d == limit_q) begin
                    timeout_set = 1'b1;
                    flush_cnt_d = '0;
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Once a full idle bit is seen, the guard runs regardless of the line.
                if (flush_cnt_q >= {1'b0, baud_q}) flush_cnt_d = flush_cnt_q + 9'd1;
                else if (i_Rx_Serial)              flush_cnt_d = flush_cnt_q + 9'd1;
                else                               flush_cnt_d = '0;
                if (i_Shift_Done || flush_cnt_d == flush_end)
                    state_d = (pend_vld_q && !pend_en_q) ? ST_OFF : ST_IDLE;
            end
            default: state_d = ST_OFF;
        endcase

        overrun_d = (push && fifo_full && !pop_fire) || (overrun_q && !i_Clr_Err);
        timeout_d = timeout_set || (timeout_q && !i_Clr_Err);
    end

    always_ff @(posedge i_Pclk) begin
        if (i_Rst) begin
            state_q     <= ST_OFF;
            baud_q      <= 8'(DEFAULT_BAUD);
            pend_baud_q <= '0;
            pend_en_q   <= 1'b0;
            pend_vld_q  <= 1'b0;
            limit_q     <= '0;
            wdog_q      <= '0;
            flush_cnt_q <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            pend_baud_q <= pend_baud_d;
            pend_en_q   <= pend_en_d;
            pend_vld_q  <= pend_vld_d;
            limit_q     <= limit_d;
            wdog_q      <= wdog_d;
            flush_cnt_q <= flush_cnt_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    usrt_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_Pclk    (i_Pclk),
        .i_Rst     (i_Rst),
        .i_Push    (push),
        .i_Wr_Data (i_Shift_Data),
        .i_Pop     (i_Rd_Ready),
        .o_Rd_Data (o_Rd_Data),
        .o_Full    (fifo_full),
        .o_Empty   (fifo_empty),
        .o_Count   (o_Count)
    );

    assign o_Baud      = baud_q;
    assign o_Rx_Enable = (state_q == ST_IDLE) || (state_q == ST_RX);
    assign o_Busy      = (state_q == ST_RX) || (state_q == ST_FLUSH);
    assign o_Rd_Valid  = !fifo_empty;
    assign o_Overrun   = overrun_q;
    assign o_Timeout   = timeout_q;

endmodule
